truth_table_extractor: RTL and testbench
========================================

TRUTH_TABLE_EXTRACTOR -- requirements
Module: truth_table_extractor

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, meaning extra hold cycles per row before sampling; legal range 0..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: sweep request, sampled only in IDLE.
REQ-005 The block SHALL have ports in1, in2, in3, in4, each output, 1 bit: stimulus driven to the 4-input circuit under test.
REQ-006 The block SHALL have port out, input, 1 bit: response of the circuit under test.
REQ-007 The block SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until the cycle before done.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when table_o is complete.
REQ-009 The block SHALL have port table_o, output, 16 bits: extracted truth-table code.
REQ-010 When TTX_COMPARE_EN is defined, the block SHALL add expected_i (input, 16), match_o (output, 1), mismatch_cnt_o (output, 5) and first_bad_row_o (output, 4).

Function
REQ-011 Row index r SHALL be {in1,in2,in3,in4}, with in1 as MSB; the sample for row r SHALL be written to table_o[15-r], so row 0 lands in the MSB.
REQ-012 The FSM SHALL have states IDLE, HOLD, SAMPLE and FINISH.
REQ-013 In IDLE with start=1, the block SHALL move to HOLD next cycle, with r=0 driven, busy=1, and table_o cleared to 0.
REQ-014 HOLD SHALL last SETTLE_CYCLES cycles, counted by the settle counter; if SETTLE_CYCLES=0, HOLD SHALL be skipped.
REQ-015 SAMPLE SHALL last one cycle and SHALL capture out into table_o[15-r] at its closing edge.
REQ-016 Each row SHALL be driven for exactly SETTLE_CYCLES+1 cycles.
REQ-017 After SAMPLE, if r<15 the block SHALL increment r and re-enter HOLD (or SAMPLE when SETTLE_CYCLES=0); if r=15 it SHALL go to FINISH.
REQ-018 FINISH SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-019 Latency from the start-accepting edge to the done-high cycle SHALL be 16*(SETTLE_CYCLES+1)+1 cycles.
REQ-020 in1..in4 SHALL hold row 15 during FINISH and SHALL return to 0 in IDLE.
REQ-021 table_o SHALL hold its value from FINISH until the next accepted start.
REQ-022 Start while busy or during FINISH SHALL be ignored; it SHALL NOT be queued.
REQ-023 Start held high continuously SHALL produce back-to-back sweeps with one IDLE cycle between FINISH and the next HOLD.
REQ-024 The row counter SHALL be 4 bits and SHALL NOT wrap mid-sweep; the 15 to 0 transition SHALL occur only via FINISH/IDLE.

Reset
REQ-025 rst=1 SHALL force, at the next edge: state IDLE, r=0, in1..in4=0, busy=0, done=0 and table_o=0; when TTX_COMPARE_EN is defined, also match_o=0, mismatch_cnt_o=0 and first_bad_row_o=0.
REQ-026 Reset mid-sweep SHALL abandon the sweep with no done pulse.
REQ-027 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-028 Macro TTX_COMPARE_EN SHALL control the comparison logic.
REQ-029 With TTX_COMPARE_EN defined, each SAMPLE SHALL compare out to expected_i[15-r] and increment mismatch_cnt_o (0..16, no saturation needed) on mismatch.
REQ-030 With TTX_COMPARE_EN defined, first_bad_row_o SHALL latch the lowest mismatching r.
REQ-031 With TTX_COMPARE_EN defined, match_o SHALL be valid during FINISH and held with table_o, equal to (mismatch_cnt_o==0).
REQ-032 With TTX_COMPARE_EN defined, all compare outputs SHALL clear on an accepted start.
REQ-033 Without TTX_COMPARE_EN, those ports and their logic SHALL be absent.

Structure
REQ-034 Package ttx_pkg SHALL hold the state enum, N_ROWS=16, the 4-bit row_t and 16-bit tt_code_t typedefs, and the row-to-bit mapping function (15-r).
REQ-035 The design SHALL have one sub-module, ttx_settle_timer: a loadable down-counter with a zero flag, parameterised by SETTLE_CYCLES.

Verification
REQ-036 Bench model 0xB744 (out = (in4&~in3) XOR (~in1&~(in2&~in3))), SETTLE_CYCLES=2, start pulse -> done exactly 49 cycles after the start edge, table_o=16'hB744; with TTX_COMPARE_EN defined and expected_i=16'hB744, match_o=1.
REQ-037 Same model, expected_i=16'hB745 -> mismatch_cnt_o=1, first_bad_row_o=15, match_o=0.
REQ-038 SETTLE_CYCLES=0, constant out=1 -> table_o=16'hFFFF, done 17 cycles after start; rows 0..15 shown one per cycle on {in1..in4}.
REQ-039 rst asserted at row 7 mid-sweep -> next cycle IDLE, in1..in4=0, table_o=0, no done; a following start gives a clean full sweep.
REQ-040 start re-pulsed at row 3, and start held high through FINISH -> first sweep unaffected; exactly one new sweep begins after a single IDLE cycle.
REQ-041 Model that inverts its output 1 cycle after the input change, SETTLE_CYCLES=1 -> table_o equals the settled function, confirming the sample lands on the last hold cycle.

Source files
------------

// File: rtl/ttx_pkg.sv
// Shared types for the truth-table extractor: FSM states, row/code types
// and the mapping from row index to table bit position.
package ttx_pkg;

    localparam int N_ROWS = 16;

    typedef logic [3:0]  row_t;
    typedef logic [15:0] tt_code_t;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SAMPLE,
        FINISH
    } state_t;

    // Row 0 lands in the MSB so the code reads left to right in row order.
    function automatic row_t row_bit(input row_t r);
        return row_t'(N_ROWS - 1) - r;
    endfunction

endpackage

// File: rtl/ttx_settle_timer.sv
// Loadable down-counter timing the settle hold of each row; zero flags the
// last hold cycle.
module ttx_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic zero
);

    // Loading SETTLE_CYCLES-1 makes zero coincide with the final hold cycle.
    localparam logic [7:0] LOAD_VAL = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 8'd0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/truth_table_extractor.sv
// Sweeps all 16 input rows of a 4-input circuit and records its response as a
// 16-bit code. Defining TTX_COMPARE_EN adds comparison against an expected code.
//
// state  | meaning
// IDLE   | rows parked at 0, waiting for start
// HOLD   | row driven, waiting for the circuit to settle
// SAMPLE | last cycle of the row, out captured at its closing edge
// FINISH | table complete, one-cycle done pulse
module truth_table_extractor
    import ttx_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     start,
    output logic     in1,
    output logic     in2,
    output logic     in3,
    output logic     in4,
    input  logic     out,
    output logic     busy,
    output logic     done,
    output tt_code_t table_o
`ifdef TTX_COMPARE_EN
    ,
    input  tt_code_t expected_i,
    output logic     match_o,
    output logic [4:0] mismatch_cnt_o,
    output row_t     first_bad_row_o
`endif
);

    localparam bit SKIP_HOLD = (SETTLE_CYCLES == 0);

    state_t   state;
    state_t   state_next;
    row_t     row;
    tt_code_t tbl;
    logic     timer_load;
    logic     timer_zero;
    logic     row_last;

    assign row_last = (row == row_t'(N_ROWS - 1));

    ttx_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .en   (state == HOLD),
        .zero (timer_zero)
    );

    always_comb begin
        state_next = state;
        timer_load = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = SKIP_HOLD ? SAMPLE : HOLD;
                    timer_load = 1'b1;
                end
            end
            HOLD: begin
                busy = 1'b1;
                if (timer_zero) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                busy = 1'b1;
                if (row_last) begin
                    state_next = FINISH;
                end else begin
                    state_next = SKIP_HOLD ? SAMPLE : HOLD;
                    timer_load = 1'b1;
                end
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            row   <= '0;
            tbl   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        row <= '0;
                        tbl <= '0;
                    end
                end
                SAMPLE: begin
                    tbl[row_bit(row)] <= out;
                    if (!row_last) begin
                        row <= row + row_t'(1);
                    end
                end
                FINISH: row <= '0;
                default: ;
            endcase
        end
    end

    assign {in1, in2, in3, in4} = row;
    assign table_o = tbl;

`ifdef TTX_COMPARE_EN
    logic row_bad;

    assign row_bad = (out != expected_i[row_bit(row)]);

    // Rows are visited in ascending order, so the first mismatch is the lowest.
    always_ff @(posedge clk) begin
        if (rst || ((state == IDLE) && start)) begin
            match_o         <= 1'b0;
            mismatch_cnt_o  <= 5'd0;
            first_bad_row_o <= '0;
        end else if (state == SAMPLE) begin
            if (row_bad) begin
                mismatch_cnt_o <= mismatch_cnt_o + 5'd1;
                if (mismatch_cnt_o == 5'd0) begin
                    first_bad_row_o <= row;
                end
            end
            if (row_last) begin
                match_o <= (mismatch_cnt_o == 5'd0) && !row_bad;
            end
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_extractor.sv
// Scoreboard bench for truth_table_extractor: three instances (SETTLE_CYCLES 2, 0, 1)
// each driving its own behavioural circuit model; the monitor checks every cycle.
`timescale 1ns/1ps
module tb_truth_table_extractor;

    localparam int NI = 3;
    localparam logic [23:0] SC_PACK = {8'd1, 8'd0, 8'd2};

    typedef struct {
        int          inst;
        int          start;
        logic [15:0] tbl;
        logic [4:0]  mism;
        logic [3:0]  first;
        logic        match;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_v [NI];
    int          mode_v  [NI];
    logic [15:0] code_v  [NI];
    logic [15:0] expv_v  [NI];
    logic [3:0]  row_w   [NI];
    logic        busy_w  [NI];
    logic        done_w  [NI];
    logic        out_v   [NI];
    logic [15:0] tbl_w   [NI];
`ifdef TTX_COMPARE_EN
    logic        match_w [NI];
    logic [4:0]  mcnt_w  [NI];
    logic [3:0]  fbad_w  [NI];
`endif

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sc_of(int i);
        return int'(SC_PACK[8*i +: 8]);
    endfunction

    function automatic int lat_of(int i);
        return 16 * (sc_of(i) + 1) + 1;
    endfunction

    // Circuit under test: 0 = the 0xB744 formula, 1 = lookup of a code, 2 = constant 1.
    function automatic logic cut_fn(int mode, logic [15:0] code, logic [3:0] r);
        logic a, b, c, d;
        {a, b, c, d} = r;
        case (mode)
            0:       return (d & ~c) ^ (~a & ~(b & ~c));
            1:       return code[15 - int'(r)];
            default: return 1'b1;
        endcase
    endfunction

    function automatic exp_t make_exp(int i, int s);
        exp_t        e;
        logic [15:0] diff;
        e.inst  = i;
        e.start = s;
        e.tbl   = '0;
        for (int r = 0; r < 16; r++) e.tbl[15 - r] = cut_fn(mode_v[i], code_v[i], 4'(r));
        diff    = e.tbl ^ expv_v[i];
        e.mism  = 5'($countones(diff));
        e.first = 4'd0;
        for (int r = 15; r >= 0; r--) if (diff[15 - r]) e.first = 4'(r);
        e.match = (diff == 16'd0);
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic        a1, a2, a3, a4, bz, dn;
        logic [15:0] tt;
        truth_table_extractor #(
            .SETTLE_CYCLES(int'(SC_PACK[8*g +: 8]))
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start_v[g]),
            .in1     (a1),
            .in2     (a2),
            .in3     (a3),
            .in4     (a4),
            .out     (out_v[g]),
            .busy    (bz),
            .done    (dn),
            .table_o (tt)
`ifdef TTX_COMPARE_EN
            ,
            .expected_i      (expv_v[g]),
            .match_o         (match_w[g]),
            .mismatch_cnt_o  (mcnt_w[g]),
            .first_bad_row_o (fbad_w[g])
`endif
        );
        assign row_w[g]  = {a1, a2, a3, a4};
        assign busy_w[g] = bz;
        assign done_w[g] = dn;
        assign tbl_w[g]  = tt;
        if (g == 2) begin : g_lag
            // Output follows the inputs one cycle late.
            logic dly;
            always @(posedge clk) dly <= cut_fn(mode_v[g], code_v[g], row_w[g]);
            assign out_v[g] = dly;
        end else begin : g_comb
            assign out_v[g] = cut_fn(mode_v[g], code_v[g], row_w[g]);
        end
    end

    always @(negedge clk) begin : mon
        exp_t h;
        int   i, s, l, handled;
        handled = -1;
        if (!rst && sb.size() > 0) begin
            h = sb[0];
            i = h.inst;
            s = sc_of(i);
            l = lat_of(i);
            if (done_w[i]) begin
                handled = i;
                chk("done_latency", cyc - h.start, l);
                chk("table", tbl_w[i], h.tbl);
                chk("busy_in_finish", busy_w[i], 0);
                chk("row_in_finish", row_w[i], 15);
`ifdef TTX_COMPARE_EN
                chk("mismatch_cnt", mcnt_w[i], h.mism);
                chk("first_bad_row", fbad_w[i], h.first);
                chk("match", match_w[i], h.match);
`endif
                void'(sb.pop_front());
            end else if (cyc - h.start > l) begin
                checks++;
                errors++;
                $display("FAIL done_timeout inst=%0d actual=no_done required=done_at_%0d", i, l);
                void'(sb.pop_front());
            end else if (cyc > h.start) begin
                chk("busy_in_sweep", busy_w[i], 1);
                chk("row_in_sweep", row_w[i], (cyc - h.start - 1) / (s + 1));
            end
        end
        if (!rst) begin
            for (int k = 0; k < NI; k++) begin
                if (k != handled) chk("no_stray_done", done_w[k], 0);
            end
        end
    end

    task automatic wait_drain();
        int n;
        for (n = 0; n < 3000; n++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        if (n == 3000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_row(int i, logic [3:0] r);
        int n;
        for (n = 0; n < 500; n++) begin
            if (row_w[i] == r) break;
            @(posedge clk); #1;
        end
        if (n == 500) begin
            checks++;
            errors++;
            $display("FAIL row_wait inst=%0d actual=%0d required=%0d", i, row_w[i], r);
        end
    endtask

    task automatic issue(int i);
        exp_t e;
        @(posedge clk); #1;
        e = make_exp(i, cyc);
        sb.push_back(e);
        start_v[i] = 1'b1;
        @(posedge clk); #1;
        start_v[i] = 1'b0;
    endtask

    task automatic run_sweep(int i, int mode, logic [15:0] code, logic [15:0] ev);
        exp_t e;
        mode_v[i] = mode;
        code_v[i] = code;
        expv_v[i] = ev;
        e = make_exp(i, 0);
        issue(i);
        wait_drain();
        chk("idle_row", row_w[i], 0);
        chk("idle_busy", busy_w[i], 0);
        chk("table_held", tbl_w[i], e.tbl);
    endtask

    task automatic check_cleared(int i);
        chk("rst_busy", busy_w[i], 0);
        chk("rst_done", done_w[i], 0);
        chk("rst_row", row_w[i], 0);
        chk("rst_table", tbl_w[i], 0);
`ifdef TTX_COMPARE_EN
        chk("rst_match", match_w[i], 0);
        chk("rst_mcnt", mcnt_w[i], 0);
        chk("rst_fbad", fbad_w[i], 0);
`endif
    endtask

    initial begin
        exp_t        e1, e2;
        logic [15:0] c;
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start_v[i] = 1'b1;
            mode_v[i]  = 2;
            code_v[i]  = '0;
            expv_v[i]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) check_cleared(i);
        rst = 1'b0;
        for (int i = 0; i < NI; i++) start_v[i] = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < NI; i++) chk("idle_after_rst", busy_w[i], 0);

        run_sweep(0, 0, 16'h0, 16'hB744);
        chk("table_b744", tbl_w[0], 16'hB744);
        run_sweep(0, 0, 16'h0, 16'hB745);

        run_sweep(1, 2, 16'h0, 16'hFFFF);
        chk("table_ones", tbl_w[1], 16'hFFFF);
        run_sweep(1, 1, 16'($urandom), 16'($urandom));

        for (int k = 0; k < 3; k++) begin
            c = 16'($urandom);
            run_sweep(2, 1, c, c ^ 16'($urandom_range(0, 3)));
        end

        for (int k = 0; k < 4; k++) begin
            c = 16'($urandom);
            run_sweep(0, 1, c, (k == 0) ? c : (k == 1) ? (c ^ (16'h1 << $urandom_range(0, 15))) : 16'($urandom));
        end

        // Reset in the middle of a sweep.
        mode_v[0] = 1;
        code_v[0] = 16'($urandom);
        expv_v[0] = 16'($urandom);
        issue(0);
        wait_row(0, 4'd7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        check_cleared(0);
        repeat (60) @(posedge clk);
        #1;
        run_sweep(0, 1, 16'($urandom), 16'($urandom));

        // Restart pulse mid-sweep, then start held through FINISH.
        mode_v[0] = 1;
        code_v[0] = 16'($urandom);
        expv_v[0] = 16'($urandom);
        @(posedge clk); #1;
        e1 = make_exp(0, cyc);
        sb.push_back(e1);
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        wait_row(0, 4'd3);
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        wait_row(0, 4'd15);
        start_v[0] = 1'b1;
        e2 = make_exp(0, e1.start + lat_of(0) + 1);
        sb.push_back(e2);
        for (int n = 0; n < 200 && cyc <= e2.start + 2; n++) begin
            @(posedge clk); #1;
        end
        start_v[0] = 1'b0;
        wait_drain();
        chk("restart_table", tbl_w[0], e2.tbl);
        repeat (70) @(posedge clk);
        #1;
        chk("no_queued_sweep", busy_w[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
